instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and issues one-outstanding-request reads to instruction memory.
- Registers the returned word into an IF/ID output register that drives the decoder's op_code, plus funct and pc_plus4.
- Honours a downstream stall and redirects on taken branches, flushing wrong-path fetches.

---
 rtl/mips_pkg.sv | 11 +
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch_skid.sv | 21 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, instruction field positions and fetch state type shared by fetch and decode.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW = 6'd35;
  localparam logic [5:0] OP_SW = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read bus.
//   req/addr from fetch; gnt accepts the request; rvalid/rdata return the word later.
interface instr_fetch_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch_skid.sv
// fetch_skid: one-entry skid buffer that parks a returned word while IF/ID is stalled.
//   load captures d, unload or flush empties it (flush wins over load).
module fetch_skid #(parameter int W = 64) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= !(flush || unload) && (load || valid);
      if (load) q <= d;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + single-outstanding instruction fetch feeding the IF/ID register.
//   clk, rst (async, active high); imem: master side of the instruction bus;
//   id_stall holds IF/ID; branch_taken/branch_target redirect and flush;
//   if_valid/if_instr/op_code/funct/if_pc_plus4 form the IF/ID register.
//   FETCH_PERF_CNT_EN adds saturating perf_fetched, perf_stall, perf_flush.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     imem,
  input  logic              id_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [5:0]        op_code,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc4;
  logic discard, discard_n, in_flight;
  logic got, load_new, park, load_skid, sk_valid;
  logic [ADDR_W+DATA_W-1:0] sk_q;
  assign pc4 = pc + ADDR_W'(4);
  assign imem.req = state == REQ;
  assign imem.addr = pc;
  assign op_code = if_instr[OPC_MSB:OPC_LSB];
  assign funct = if_instr[5:0];
  assign got = state == WAIT && imem.rvalid && !discard && !branch_taken;
  assign load_new = got && (!if_valid || !id_stall);
  assign park = got && if_valid && id_stall;
  assign load_skid = state == HOLD && sk_valid && !id_stall && !branch_taken;
  // A redirect leaves a response owed to us when the request was just granted
  // or is still outstanding; that response must be swallowed before refetching.
  assign in_flight = (state == REQ && imem.gnt) || (state == WAIT && !imem.rvalid);
  always_comb begin
    state_n = state;
    pc_n = pc;
    discard_n = discard;
    if (branch_taken) begin
      pc_n = branch_target;
      discard_n = in_flight;
      state_n = in_flight ? WAIT : REQ;
    end else begin
      unique case (state)
        IDLE: state_n = REQ;
        REQ:  state_n = imem.gnt ? WAIT : REQ;
        WAIT: if (imem.rvalid) begin
          discard_n = 1'b0;
          pc_n = discard ? pc : pc4;
          state_n = (discard || !if_valid || !id_stall) ? REQ : HOLD;
        end
        HOLD: state_n = id_stall ? HOLD : REQ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc_plus4 <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      discard <= discard_n;
      if_valid <= !branch_taken && (load_new || load_skid || (if_valid && id_stall));
      if (load_new) begin
        if_instr <= imem.rdata;
        if_pc_plus4 <= pc4;
      end else if (load_skid) {if_pc_plus4, if_instr} <= sk_q;
    end
  fetch_skid #(.W(ADDR_W + DATA_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .load(park),
    .unload(load_skid),
    .flush(branch_taken),
    .d({pc4, imem.rdata}),
    .valid(sk_valid),
    .q(sk_q)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if ((load_new || load_skid) && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (if_valid && id_stall && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
      if (branch_taken && !(&perf_flush)) perf_flush <= perf_flush + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, stall/skid, redirects, PC wrap and reset.
module tb_instr_fetch;
  logic clk = 1'b0, rst = 1'b1, id_stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic gnt_en = 1'b1, inj_rv = 1'b0;
  int lat = 1;
  logic p1_v = 1'b0, p2_v = 1'b0, q_v = 1'b0;
  logic [31:0] p1_a = '0, p2_a = '0, q_a = '0;
  logic if_valid, w_valid;
  logic [31:0] if_instr, if_pc_plus4, w_instr, w_pc4;
  logic [5:0] op_code, funct, w_op, w_funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_pf, w_ps;
  logic [15:0] perf_flush, w_pl;
`endif
  int n_cmp = 0, n_bad = 0;
  instr_fetch_if m();
  instr_fetch_if w();
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:2], 10'h0, a[15:0]} ^ 32'h8C22_0004;
  endfunction
  assign m.gnt = gnt_en;
  assign m.rvalid = (lat == 1 ? p1_v : p2_v) | inj_rv;
  assign m.rdata = word_at(lat == 1 ? p1_a : p2_a);
  assign w.gnt = 1'b1;
  assign w.rvalid = q_v;
  assign w.rdata = word_at(q_a);
  always @(posedge clk) begin
    p1_v <= m.req & m.gnt;
    p1_a <= m.addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
    q_v <= w.req;
    q_a <= w.addr;
  end
  instr_fetch dut (
    .clk(clk), .rst(rst), .imem(m), .id_stall(id_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .op_code(op_code),
    .funct(funct), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem(w), .id_stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .if_valid(w_valid), .if_instr(w_instr), .op_code(w_op),
    .funct(w_funct), .if_pc_plus4(w_pc4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_stall(w_ps), .perf_flush(w_pl)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    tick(2);
    check("rst_req", m.req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc4", if_pc_plus4, 0);
    rst = 1'b0;
    tick;
    check("req0", m.req, 1);
    check("addr0", m.addr, 32'h0);
    check("wrap_addr0", w.addr, 32'hFFFF_FFFC);
    tick;
    check("wait_noreq", m.req, 0);
    tick;
    check("f0_valid", if_valid, 1);
    check("f0_pc4", if_pc_plus4, 32'h4);
    check("f0_op", op_code, 35);
    check("f0_funct", funct, 4);
    check("addr4", m.addr, 32'h4);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_addr", w.addr, 32'h0);
    check("wrap_valid", w_valid, 1);
    tick;
    check("consumed", if_valid, 0);
    tick;
    check("f1_pc4", if_pc_plus4, 32'h8);
    check("f1_op", op_code, 34);
    check("addr8", m.addr, 32'h8);
    tick(2);
    check("f2_pc4", if_pc_plus4, 32'hC);
    check("f2_op", op_code, 33);
    check("f2_funct", funct, 12);
    id_stall = 1'b1;
    tick(2);
    check("hold_noreq", m.req, 0);
    check("hold_valid", if_valid, 1);
    check("hold_pc4", if_pc_plus4, 32'hC);
    tick(2);
    check("hold_noreq2", m.req, 0);
    check("hold_pc4_2", if_pc_plus4, 32'hC);
    id_stall = 1'b0;
    tick;
    check("skid_valid", if_valid, 1);
    check("skid_pc4", if_pc_plus4, 32'h10);
    check("skid_op", op_code, 32);
    check("skid_funct", funct, 8);
    check("addr16", m.addr, 32'h10);
    tick;
    check("skid_nodup", if_valid, 0);
    tick;
    check("after_skid_pc4", if_pc_plus4, 32'h14);
    lat = 2;
    tick;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick;
    branch_taken = 1'b0;
    check("br_wait_valid", if_valid, 0);
    check("br_wait_noreq", m.req, 0);
    tick;
    check("stale_dropped", if_valid, 0);
    check("br_req", m.req, 1);
    check("br_addr", m.addr, 32'h40);
    lat = 1;
    tick(2);
    check("br_pc4", if_pc_plus4, 32'h44);
    check("br_instr", if_instr, 32'hCC22_0044);
    check("br_op", op_code, 51);
    branch_taken = 1'b1;
    branch_target = 32'h80;
    tick;
    branch_taken = 1'b0;
    check("brg_valid", if_valid, 0);
    tick;
    check("brg_dropped", if_valid, 0);
    check("brg_addr", m.addr, 32'h80);
    tick(2);
    check("brg_instr", if_instr, 32'h0C22_0084);
    check("brg_pc4", if_pc_plus4, 32'h84);
    id_stall = 1'b1;
    tick(2);
    check("hold2_noreq", m.req, 0);
    check("hold2_valid", if_valid, 1);
    branch_taken = 1'b1;
    branch_target = 32'h100;
    tick;
    branch_taken = 1'b0;
    id_stall = 1'b0;
    check("brh_valid", if_valid, 0);
    check("brh_addr", m.addr, 32'h100);
    tick;
    check("brh_skid_gone", if_valid, 0);
    tick;
    check("brh_instr", if_instr, 32'h8C22_0104);
    check("brh_pc4", if_pc_plus4, 32'h104);
    gnt_en = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    tick;
    branch_taken = 1'b0;
    check("brq_req", m.req, 1);
    check("brq_addr", m.addr, 32'h200);
    gnt_en = 1'b1;
    tick(2);
    check("brq_pc4", if_pc_plus4, 32'h204);
`ifdef FETCH_PERF_CNT_EN
    check("perf_flush4", perf_flush, 4);
`endif
    tick;
    lat = 2;
    gnt_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", if_valid, 0);
    check("mid_rst_instr", if_instr, 0);
    check("mid_rst_pc4", if_pc_plus4, 0);
    check("mid_rst_req", m.req, 0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_rst_fetched", perf_fetched, 0);
    check("perf_rst_flush", perf_flush, 0);
`endif
    tick;
    rst = 1'b0;
    tick;
    inj_rv = 1'b1;
    tick;
    inj_rv = 1'b0;
    check("late_rv_valid", if_valid, 0);
    check("restart_req", m.req, 1);
    check("restart_addr", m.addr, 32'h0);
    gnt_en = 1'b1;
    lat = 1;
    tick(2);
    check("restart_valid", if_valid, 1);
    check("restart_pc4", if_pc_plus4, 32'h4);
    check("restart_op", op_code, 35);
`ifdef FETCH_PERF_CNT_EN
    tick(18);
    check("perf_fetched10", perf_fetched, 10);
    id_stall = 1'b1;
    tick(3);
    check("perf_fetched_hold", perf_fetched, 10);
    check("perf_stall3", perf_stall, 3);
    check("perf_flush0", perf_flush, 0);
    id_stall = 1'b0;
    tick;
    check("perf_fetched11", perf_fetched, 11);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
